// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for a WIDTH-bit shift-and-add multiplier: sequences LOAD, TEST, ADD and SHIFT
// strobes for an external datapath and reports completion with a one-cycle DONE pulse.
module shift_add_mult_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         START,
   input  logic                         CLR,
   input  logic                         Q0,
   output logic                         LOAD,
   output logic                         CLRACC,
   output logic                         ADD,
   output logic                         SHIFT,
   output logic                         BUSY,
   output logic                         DONE,
   output logic [5:0]                   STATE,
   output logic [$clog2(WIDTH+1)-1:0]   COUNT
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [5:0] S_IDLE  = 6'b000001;
   localparam logic [5:0] S_LOAD  = 6'b000010;
   localparam logic [5:0] S_TEST  = 6'b000100;
   localparam logic [5:0] S_ADD   = 6'b001000;
   localparam logic [5:0] S_SHIFT = 6'b010000;
   localparam logic [5:0] S_DONE  = 6'b100000;

   localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
   localparam logic [CW-1:0] COUNT_ZERO = CW'(0);

   logic [5:0]    state_r;
   logic [5:0]    state_nxt_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;

   // Next-state logic; CLR overrides every transition, illegal encodings recover to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      if (CLR) begin
         state_nxt_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (START) state_nxt_s = S_LOAD;
               else       state_nxt_s = S_IDLE;
            end
            S_LOAD:  state_nxt_s = S_TEST;
            S_TEST: begin
               if (Q0) state_nxt_s = S_ADD;
               else    state_nxt_s = S_SHIFT;
            end
            S_ADD:   state_nxt_s = S_SHIFT;
            S_SHIFT: begin
               if (count_r == COUNT_ONE) state_nxt_s = S_DONE;
               else                      state_nxt_s = S_TEST;
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
         endcase
      end
   end

   // Iteration counter: reloaded at the end of LOAD, stepped down at the end of each SHIFT, never below zero.
   always_comb begin
      count_nxt_s = count_r;
      if (CLR) begin
         count_nxt_s = count_r;
      end else begin
         case (state_r)
            S_LOAD: count_nxt_s = COUNT_INIT;
            S_SHIFT: begin
               if (count_r != COUNT_ZERO) count_nxt_s = count_r - COUNT_ONE;
               else                       count_nxt_s = COUNT_ZERO;
            end
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // State and counter registers with asynchronous reset to IDLE / zero.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r <= S_IDLE;
         count_r <= COUNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         count_r <= count_nxt_s;
      end
   end

   // Moore outputs are individual bits of the one-hot state register.
   assign LOAD   = state_r[1];
   assign CLRACC = state_r[1];
   assign ADD    = state_r[3];
   assign SHIFT  = state_r[4];
   assign DONE   = state_r[5];
   assign BUSY   = ~state_r[0];
   assign STATE  = state_r;
   assign COUNT  = count_r;

endmodule
